// File: rtl/secuenciador_muestreo.sv
// Sampling sequencer and thermal controller: periodically requests a sensor reading,
// registers the temperature and drives fan/alarm with hysteresis, with fail-safe on timeout.
module secuenciador_muestreo #(
    parameter int unsigned PERIODO_MUESTRA = 1000,
    parameter int unsigned TIMEOUT         = 255,
    parameter int unsigned T_VENT_ON       = 25,
    parameter int unsigned T_VENT_OFF      = 22,
    parameter int unsigned T_ALARMA_ON     = 30,
    parameter int unsigned T_ALARMA_OFF    = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_m1,
    input  logic [4:0] temperatura,
    input  logic       dato_listo,
    output logic       lect,
    output logic [4:0] temp_reg,
    output logic       muestra_valida,
    output logic       est_ventilador,
    output logic       est_alarma,
    output logic       fallo
);

    localparam int unsigned CntW  = (PERIODO_MUESTRA > 1) ? $clog2(PERIODO_MUESTRA) : 1;
    localparam int unsigned TcntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CntW-1:0]  CntFin    = CntW'(PERIODO_MUESTRA - 1);
    localparam logic [TcntW-1:0] TcntFin   = TcntW'(TIMEOUT - 1);
    localparam logic [4:0]       VentOn    = 5'(T_VENT_ON);
    localparam logic [4:0]       VentOff   = 5'(T_VENT_OFF);
    localparam logic [4:0]       AlarmaOn  = 5'(T_ALARMA_ON);
    localparam logic [4:0]       AlarmaOff = 5'(T_ALARMA_OFF);

    typedef enum logic [1:0] {
        StIdle,
        StEspera,
        StSolicita
    } estado_e;

    estado_e          estado;
    logic [CntW-1:0]  cnt;
    logic [TcntW-1:0] tcnt;

    logic alarma_nueva;
    logic vent_nuevo;

    // Hysteresis starts from the currently held commands, including fail-safe values.
    always_comb begin
        alarma_nueva = est_alarma;
        if (temperatura >= AlarmaOn) begin
            alarma_nueva = 1'b1;
        end else if (temperatura <= AlarmaOff) begin
            alarma_nueva = 1'b0;
        end

        vent_nuevo = est_ventilador;
        if (temperatura >= VentOn) begin
            vent_nuevo = 1'b1;
        end else if (temperatura <= VentOff) begin
            vent_nuevo = 1'b0;
        end
        if (alarma_nueva) begin
            vent_nuevo = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= StIdle;
            cnt            <= '0;
            tcnt           <= '0;
            lect           <= 1'b0;
            temp_reg       <= '0;
            muestra_valida <= 1'b0;
            est_ventilador <= 1'b0;
            est_alarma     <= 1'b0;
            fallo          <= 1'b0;
        end else begin
            muestra_valida <= 1'b0;
            if (!en_m1) begin
                // Disable wins over any pending sample; results are held.
                estado <= StIdle;
                lect   <= 1'b0;
                cnt    <= '0;
                tcnt   <= '0;
            end else begin
                case (estado)
                    StIdle: begin
                        estado <= StSolicita;
                        lect   <= 1'b1;
                        cnt    <= '0;
                        tcnt   <= '0;
                    end
                    StEspera: begin
                        if (cnt == CntFin) begin
                            estado <= StSolicita;
                            lect   <= 1'b1;
                            cnt    <= '0;
                            tcnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StSolicita: begin
                        if (dato_listo) begin
                            temp_reg       <= temperatura;
                            est_ventilador <= vent_nuevo;
                            est_alarma     <= alarma_nueva;
                            fallo          <= 1'b0;
                            muestra_valida <= 1'b1;
                            estado         <= StEspera;
                            lect           <= 1'b0;
                            cnt            <= '0;
                            tcnt           <= '0;
                        end else if (tcnt == TcntFin) begin
                            fallo          <= 1'b1;
                            est_ventilador <= 1'b1;
                            est_alarma     <= 1'b1;
                            estado         <= StEspera;
                            lect           <= 1'b0;
                            cnt            <= '0;
                            tcnt           <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: begin
                        estado <= StIdle;
                        lect   <= 1'b0;
                        cnt    <= '0;
                        tcnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// Bench for secuenciador_muestreo: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based behavioural model.
module tb_secuenciador_muestreo;

    localparam int P  = 8;
    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en_m1 = 1'b0;
    logic [4:0] temperatura = '0;
    logic       dato_listo = 1'b0;
    logic       lect;
    logic [4:0] temp_reg;
    logic       muestra_valida;
    logic       est_ventilador;
    logic       est_alarma;
    logic       fallo;

    int vectores = 0;
    int fallos   = 0;

    secuenciador_muestreo #(
        .PERIODO_MUESTRA(P),
        .TIMEOUT        (TO),
        .T_VENT_ON      (25),
        .T_VENT_OFF     (22),
        .T_ALARMA_ON    (30),
        .T_ALARMA_OFF   (28)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en_m1         (en_m1),
        .temperatura   (temperatura),
        .dato_listo    (dato_listo),
        .lect          (lect),
        .temp_reg      (temp_reg),
        .muestra_valida(muestra_valida),
        .est_ventilador(est_ventilador),
        .est_alarma    (est_alarma),
        .fallo         (fallo)
    );

    always #5 clock = ~clock;

    // Model: tracks when the request started and when the next one is due, in absolute edges.
    int         n = 0;
    bit         m_activo = 0;
    bit         m_pide = 0;
    int         m_t_ini = 0;
    int         m_t_prox = 0;
    logic [4:0] m_temp = '0;
    bit         m_mv = 0;
    bit         m_fan = 0;
    bit         m_alarm = 0;
    bit         m_fallo = 0;

    always @(posedge clock) begin
        bit a;
        bit f;
        logic [9:0] esperado;
        logic [9:0] actual;
        if (!reset) begin
            m_activo = 0; m_pide = 0; m_temp = '0; m_mv = 0;
            m_fan = 0; m_alarm = 0; m_fallo = 0;
        end else begin
            n++;
            m_mv = 0;
            if (!en_m1) begin
                m_activo = 0;
                m_pide   = 0;
            end else if (!m_activo) begin
                m_activo = 1;
                m_pide   = 1;
                m_t_ini  = n;
            end else if (m_pide) begin
                if (dato_listo) begin
                    a = (temperatura >= 30) ? 1'b1 : (temperatura <= 28) ? 1'b0 : m_alarm;
                    f = a ? 1'b1 : (temperatura >= 25) ? 1'b1 : (temperatura <= 22) ? 1'b0 : m_fan;
                    m_alarm  = a;
                    m_fan    = f;
                    m_temp   = temperatura;
                    m_fallo  = 0;
                    m_mv     = 1;
                    m_pide   = 0;
                    m_t_prox = n + P;
                end else if (n - m_t_ini == TO) begin
                    m_fallo  = 1;
                    m_fan    = 1;
                    m_alarm  = 1;
                    m_pide   = 0;
                    m_t_prox = n + P;
                end
            end else if (n == m_t_prox) begin
                m_pide  = 1;
                m_t_ini = n;
            end
        end
        #1;
        if (reset) begin
            esperado = {m_pide, m_temp, m_mv, m_fan, m_alarm, m_fallo};
            actual   = {lect, temp_reg, muestra_valida, est_ventilador, est_alarma, fallo};
            vectores++;
            if (actual !== esperado) begin
                fallos++;
                $display("FAIL model t=%0t {lect,temp,mv,fan,alarm,fallo}: got %b required %b",
                         $time, actual, esperado);
            end
        end
    end

    task automatic chk(input string nombre, input logic [15:0] act, input logic [15:0] req);
        vectores++;
        if (act !== req) begin
            fallos++;
            $display("FAIL %s t=%0t: got %0d required %0d", nombre, $time, act, req);
        end
    endtask

    // Leaves the bench at a negedge where lect is high; bounded.
    task automatic esperar_lect();
        int k;
        k = 0;
        while (lect !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (lect !== 1'b1) chk("lect_timeout", 16'(lect), 16'd1);
    endtask

    task automatic muestra(input logic [4:0] t);
        esperar_lect();
        dato_listo  = 1'b1;
        temperatura = t;
        @(negedge clock);
        dato_listo = 1'b0;
        chk("mv_pulse", 16'(muestra_valida), 16'd1);
        chk("temp_reg", 16'(temp_reg), 16'(t));
    endtask

    logic [4:0] sweep_t  [5] = '{5'd24, 5'd25, 5'd23, 5'd22, 5'd24};
    bit         sweep_f  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] alarm_t  [4] = '{5'd30, 5'd29, 5'd28, 5'd27};
    bit         alarm_a  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int k;
        // 1. Reset and first sample
        repeat (3) @(negedge clock);
        chk("reset_outputs", 16'({lect, temp_reg, muestra_valida, est_ventilador,
                                  est_alarma, fallo}), 16'd0);
        reset = 1'b1;
        en_m1 = 1'b1;
        @(negedge clock);
        chk("first_lect", 16'(lect), 16'd1);
        @(negedge clock);
        dato_listo  = 1'b1;
        temperatura = 5'd20;
        @(negedge clock);
        dato_listo = 1'b0;
        chk("t1_temp", 16'(temp_reg), 16'd20);
        chk("t1_mv", 16'(muestra_valida), 16'd1);
        chk("t1_fan_alarm", 16'({est_ventilador, est_alarma}), 16'd0);
        chk("t1_lect_low", 16'(lect), 16'd0);
        k = 0;
        while (lect !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("t1_period", 16'(k), 16'(P));

        // 2. Fan hysteresis sweep
        for (int i = 0; i < 5; i++) begin
            muestra(sweep_t[i]);
            chk("t2_fan", 16'(est_ventilador), 16'(sweep_f[i]));
            chk("t2_alarm", 16'(est_alarma), 16'd0);
        end

        // 3. Alarm hysteresis
        for (int i = 0; i < 4; i++) begin
            muestra(alarm_t[i]);
            chk("t3_alarm", 16'(est_alarma), 16'(alarm_a[i]));
            chk("t3_fan", 16'(est_ventilador), 16'd1);
        end

        // 4. Timeout into fail-safe, then recovery
        esperar_lect();
        repeat (TO - 1) @(negedge clock);
        chk("t4_no_early_fallo", 16'({lect, fallo}), 16'b10);
        @(negedge clock);
        chk("t4_fallo", 16'(fallo), 16'd1);
        chk("t4_failsafe", 16'({est_ventilador, est_alarma}), 16'b11);
        chk("t4_lect_low", 16'(lect), 16'd0);
        chk("t4_temp_held", 16'(temp_reg), 16'd27);
        muestra(5'd20);
        chk("t4_recover", 16'({fallo, est_ventilador, est_alarma}), 16'd0);

        // 5. Disable with simultaneous data-ready
        esperar_lect();
        en_m1       = 1'b0;
        dato_listo  = 1'b1;
        temperatura = 5'd5;
        @(negedge clock);
        dato_listo = 1'b0;
        chk("t5_lect_low", 16'(lect), 16'd0);
        chk("t5_no_mv", 16'(muestra_valida), 16'd0);
        chk("t5_temp_held", 16'(temp_reg), 16'd20);
        en_m1 = 1'b1;
        @(negedge clock);
        chk("t5_reenable", 16'(lect), 16'd1);

        // 6. Asynchronous reset between edges
        #2 reset = 1'b0;
        #1 chk("t6_async_reset", 16'({lect, temp_reg, muestra_valida, est_ventilador,
                                      est_alarma, fallo}), 16'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_lect_again", 16'(lect), 16'd1);
        muestra(5'd26);
        chk("t6_fan_alarm", 16'({est_ventilador, est_alarma}), 16'b10);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            en_m1       = ($urandom_range(0, 39) != 0);
            dato_listo  = ($urandom_range(0, 4) == 0);
            temperatura = 5'($urandom_range(31, 0));
        end
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
